// File: rtl/p_encoder_pkg.sv
// Shared constants and helpers for the sticky priority encoder.
// Used by p_encoder_n and p_encoder_pending.
package p_encoder_pkg;

    localparam int P_ENC_N_MAX     = 256;
    localparam int P_ENC_IDX_W_MAX = 8;

    // Index width for an n-line encoder; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [P_ENC_N_MAX-1:0] onehot_dec(input logic [P_ENC_IDX_W_MAX-1:0] idx);
        logic [P_ENC_N_MAX-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/p_encoder_n.sv
// Combinational N-to-W priority encoder: the highest set index wins.
// idx is 0 whenever no request is set.
module p_encoder_n
    import p_encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) idx = W'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/p_encoder_pending.sv
// Sticky priority encoder with valid/ready handshake and overflow flag.
// Define P_ENCODER_ROUND_ROBIN_EN for rotating priority; default is fixed priority.
module p_encoder_pending
    import p_encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    output logic [W-1:0] e,
    output logic         v,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         ovf
);

    logic         accept;
    logic [N-1:0] clr;
    logic [N-1:0] enc_req;
    logic [W-1:0] enc_idx;
    logic         enc_valid;

    assign accept = v & ready;
    assign clr    = accept ? N'(onehot_dec(P_ENC_IDX_W_MAX'(e))) : '0;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | in;
            ovf     <= |(in & pending & ~clr);
        end
    end

`ifdef P_ENCODER_ROUND_ROBIN_EN
    logic [W-1:0]   ptr;
    logic [2*N-1:0] dbl;
    int             sel_sum;

    // Rotate so that pending[ptr] lands on the top (highest priority) bit.
    assign dbl     = {pending, pending};
    assign enc_req = N'(dbl >> (int'(ptr) + 1));

    always_comb begin
        sel_sum = int'(enc_idx) + int'(ptr) + 1;
        if (sel_sum >= N) sel_sum = sel_sum - N;
        e = enc_valid ? W'(sel_sum) : '0;
    end

    // The granted line becomes lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= W'(N - 1);
        end else if (accept) begin
            ptr <= (e == '0) ? W'(N - 1) : e - W'(1);
        end
    end
`else
    assign enc_req = pending;
    assign e       = enc_idx;
`endif

    p_encoder_n #(.N(N)) u_enc (
        .req   (enc_req),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign v = enc_valid;

endmodule
